// File: rtl/axil_reg_responder.sv
// axil_reg_responder: AXI4-Lite responder over a bank of 32-bit registers.
// Write address and write data are captured independently and committed one
// cycle after both are held; one write may be outstanding at a time. Reads
// return one beat per address. Register contents and per-register write
// pulses are exported for peripheral logic.
// Optional feature macro: AXIL_REG_SLVERR_EN. When defined, addresses beyond
// the register bank get SLVERR; when not defined, the index wraps and all
// responses are OKAY.
module axil_reg_responder #(
  parameter int          P_NUM_REGS   = 8,
  parameter int          P_ADDR_WIDTH = 32,
  parameter logic [31:0] P_RESET_VAL  = 32'h0000_0000
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [P_ADDR_WIDTH-1:0]  S_AXI_AWADDR,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [P_ADDR_WIDTH-1:0]  S_AXI_ARADDR,
  input  logic [2:0]               S_AXI_ARPROT,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [32*P_NUM_REGS-1:0] reg_q,
  output logic [P_NUM_REGS-1:0]    wr_pulse
);

  localparam int IW = (P_NUM_REGS > 1) ? $clog2(P_NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0]   regs [P_NUM_REGS];
  logic          aw_held, w_held;
  logic [IW-1:0] aw_idx;
  logic          aw_oor;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic          bvalid, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;

  logic aw_hs, w_hs, ar_hs, commit;
  logic aw_addr_oor, ar_addr_oor;
  logic [IW-1:0] ar_idx;
  logic unused_in;

  assign S_AXI_AWREADY = !aw_held && !bvalid;
  assign S_AXI_WREADY  = !w_held && !bvalid;
  assign S_AXI_ARREADY = !rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = aw_held && w_held;
  assign ar_idx = S_AXI_ARADDR[2 +: IW];

`ifdef AXIL_REG_SLVERR_EN
  assign aw_addr_oor = |S_AXI_AWADDR[P_ADDR_WIDTH-1:IW+2];
  assign ar_addr_oor = |S_AXI_ARADDR[P_ADDR_WIDTH-1:IW+2];
`else
  assign aw_addr_oor = 1'b0;
  assign ar_addr_oor = 1'b0;
`endif

  // Protection bits, byte offset and (when wrapping) upper address bits carry no meaning here.
  assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                       S_AXI_AWADDR[P_ADDR_WIDTH-1:IW+2], S_AXI_ARADDR[P_ADDR_WIDTH-1:IW+2]};

  for (genvar k = 0; k < P_NUM_REGS; k++) begin : g_flat
    assign reg_q[32*k +: 32] = regs[k];
  end

  // Write channel capture, commit and response handshake.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      aw_oor  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[2 +: IW];
        aw_oor  <= aw_addr_oor;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      // Readies are low while both flags are set, so commit never overlaps a capture.
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_oor ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Register bank with byte-strobed commit and one-cycle write pulse.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int k = 0; k < P_NUM_REGS; k++) regs[k] <= P_RESET_VAL;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit && !aw_oor) begin
        for (int b = 0; b < 4; b++) begin
          if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
        wr_pulse[aw_idx] <= 1'b1;
      end
    end
  end

  // Read channel: sample the bank on the AR handshake, hold until RREADY.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= ar_addr_oor ? 32'h0 : regs[ar_idx];
      rresp  <= ar_addr_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_reg_responder.sv
// Testbench for axil_reg_responder: directed scenarios plus a randomized
// write/read mix checked against a word-array model of the register bank.
module tb_axil_reg_responder;
  localparam int NREGS = 8;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [32*NREGS-1:0] reg_q;
  logic [NREGS-1:0] wr_pulse;

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] model [NREGS];

  always #5 ACLK = ~ACLK;

  axil_reg_responder #(.P_NUM_REGS(NREGS), .P_ADDR_WIDTH(32), .P_RESET_VAL(32'h0)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  // ---------------- reference model ----------------
  function automatic bit is_oor(input logic [31:0] a);
`ifdef AXIL_REG_SLVERR_EN
    return a >= 32'(NREGS * 4);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % NREGS);
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (is_oor(a)) return 2'b10;
    for (int b = 0; b < 4; b++)
      if (s[b]) model[idx_of(a)][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [32*NREGS-1:0] model_flat();
    logic [32*NREGS-1:0] f;
    for (int k = 0; k < NREGS; k++) f[32*k +: 32] = model[k];
    return f;
  endfunction

  function automatic logic [NREGS-1:0] exp_pulse(input logic [31:0] a);
    logic [NREGS-1:0] m = '0;
    if (!is_oor(a)) m[idx_of(a)] = 1'b1;
    return m;
  endfunction

  // ---------------- bus drivers (no checking) ----------------
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output int b_lat, output int bheld,
                           output logic [NREGS-1:0] pmask, output int pcount, output int poff,
                           output int ready_in_b, output bit tmo);
    int cyc = 0, aw_c = -1, w_c = -1, bf = -1, pf = -1, bcnt = 0;
    bit done = 0;
    pmask = '0; pcount = 0; ready_in_b = 0; tmo = 0; resp = 2'bxx;
    awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom);
    while (!done) begin
      awvalid = (aw_c < 0) && (cyc >= aw_dly);
      wvalid  = (w_c < 0) && (cyc >= w_dly);
      bready  = bvalid && (bcnt >= b_dly);
      if (wr_pulse != '0) begin pmask |= wr_pulse; pcount++; if (pf < 0) pf = cyc; end
      if (bvalid) begin
        if (bf < 0) bf = cyc;
        bcnt++;
        if (awready || wready) ready_in_b++;
      end
      if (awvalid && awready) aw_c = cyc;
      if (wvalid && wready) w_c = cyc;
      if (bvalid && bready) begin resp = bresp; done = 1; end
      if (cyc >= 200) begin tmo = 1; done = 1; end
      @(posedge ACLK); #1; cyc++;
    end
    awvalid = 0; wvalid = 0; bready = 0;
    b_lat = bf - ((aw_c > w_c) ? aw_c : w_c);
    bheld = bcnt;
    poff = pf - bf;
  endtask

  task automatic axi_read(input logic [31:0] a, input int r_dly,
                          output logic [31:0] d, output logic [1:0] resp, output int lat, output bit tmo);
    int cyc = 0, ar_c = -1, rf = -1, rcnt = 0;
    bit done = 0;
    araddr = a; arprot = 3'($urandom); tmo = 0; d = 'x; resp = 2'bxx;
    while (!done) begin
      arvalid = (ar_c < 0);
      rready  = rvalid && (rcnt >= r_dly);
      if (rvalid) begin if (rf < 0) rf = cyc; rcnt++; end
      if (arvalid && arready) ar_c = cyc;
      if (rvalid && rready) begin d = rdata; resp = rresp; done = 1; end
      if (cyc >= 200) begin tmo = 1; done = 1; end
      @(posedge ACLK); #1; cyc++;
    end
    arvalid = 0; rready = 0;
    lat = rf - ar_c;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; awprot = 0; arprot = 0;
    ARESETn = 0;
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1;
    for (int k = 0; k < NREGS; k++) model[k] = 32'h0;
    @(posedge ACLK); #1;
    n_checks++; if (awready !== 1'b1) $display("FAIL reset_awready got=%b exp=1", awready); else n_pass++;
    n_checks++; if (wready !== 1'b1) $display("FAIL reset_wready got=%b exp=1", wready); else n_pass++;
    n_checks++; if (arready !== 1'b1) $display("FAIL reset_arready got=%b exp=1", arready); else n_pass++;
    n_checks++; if (bvalid !== 1'b0) $display("FAIL reset_bvalid got=%b exp=0", bvalid); else n_pass++;
    n_checks++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", rvalid); else n_pass++;
    n_checks++; if (bresp !== 2'b00 || rresp !== 2'b00) $display("FAIL reset_resp got=%b/%b exp=00/00", bresp, rresp); else n_pass++;
    n_checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdata); else n_pass++;
    n_checks++; if (wr_pulse !== '0) $display("FAIL reset_wr_pulse got=%b exp=0", wr_pulse); else n_pass++;
    n_checks++; if (reg_q !== model_flat()) $display("FAIL reset_regs got=%h exp=%h", reg_q, model_flat()); else n_pass++;
  endtask

  task automatic test_basic_write_read();
    logic [1:0] resp; logic [31:0] d; logic [NREGS-1:0] pm;
    int blat, bheld, pc, po, rib, lat; bit tmo, tmo2;
    axi_write(32'h8, 32'h6, 4'hF, 0, 0, 0, resp, blat, bheld, pm, pc, po, rib, tmo);
    void'(model_write(32'h8, 32'h6, 4'hF));
    n_checks++; if (tmo) $display("FAIL basic_wr_timeout got=timeout exp=bresp"); else n_pass++;
    n_checks++; if (resp !== 2'b00) $display("FAIL basic_bresp got=%b exp=00", resp); else n_pass++;
    n_checks++; if (blat != 2) $display("FAIL basic_b_latency got=%0d exp=2", blat); else n_pass++;
    n_checks++; if (pm !== 8'b0000_0100 || pc != 1 || po != 0)
      $display("FAIL basic_wr_pulse got=%b/%0d/%0d exp=00000100/1/0", pm, pc, po); else n_pass++;
    n_checks++; if (reg_q[64 +: 32] !== 32'h6) $display("FAIL basic_reg2 got=%h exp=6", reg_q[64 +: 32]); else n_pass++;
    n_checks++; if (bvalid !== 1'b0 || awready !== 1'b1)
      $display("FAIL basic_b_release got=bvalid %b awready %b exp=0 1", bvalid, awready); else n_pass++;
    axi_read(32'h8, 0, d, resp, lat, tmo2);
    n_checks++; if (tmo2) $display("FAIL basic_rd_timeout got=timeout exp=rvalid"); else n_pass++;
    n_checks++; if (d !== 32'h6 || resp !== 2'b00) $display("FAIL basic_read got=%h/%b exp=6/00", d, resp); else n_pass++;
    n_checks++; if (lat != 1) $display("FAIL basic_r_latency got=%0d exp=1", lat); else n_pass++;
  endtask

  task automatic test_strobe_w_first();
    logic [1:0] resp; logic [NREGS-1:0] pm;
    int blat, bheld, pc, po, rib; bit tmo;
    axi_write(32'h4, 32'h1122_3344, 4'hF, 0, 0, 0, resp, blat, bheld, pm, pc, po, rib, tmo);
    void'(model_write(32'h4, 32'h1122_3344, 4'hF));
    axi_write(32'h4, 32'hAABB_CCDD, 4'b0101, 3, 0, 5, resp, blat, bheld, pm, pc, po, rib, tmo);
    void'(model_write(32'h4, 32'hAABB_CCDD, 4'b0101));
    n_checks++; if (tmo) $display("FAIL strobe_timeout got=timeout exp=bresp"); else n_pass++;
    n_checks++; if (reg_q[32 +: 32] !== 32'h11BB_33DD) $display("FAIL strobe_reg1 got=%h exp=11bb33dd", reg_q[32 +: 32]); else n_pass++;
    n_checks++; if (reg_q[32 +: 32] !== model[1]) $display("FAIL strobe_model got=%h exp=%h", reg_q[32 +: 32], model[1]); else n_pass++;
    n_checks++; if (blat != 2) $display("FAIL strobe_b_latency got=%0d exp=2", blat); else n_pass++;
    n_checks++; if (bheld != 6) $display("FAIL strobe_bvalid_held got=%0d exp=6", bheld); else n_pass++;
    n_checks++; if (rib != 0) $display("FAIL strobe_ready_during_b got=%0d exp=0", rib); else n_pass++;
    n_checks++; if (resp !== 2'b00) $display("FAIL strobe_bresp got=%b exp=00", resp); else n_pass++;
  endtask

  task automatic test_read_during_commit();
    logic [31:0] old_v, new_v, d; logic [1:0] resp; int lat; bit tmo;
    old_v = model[3];
    new_v = $urandom;
    if (new_v == old_v) new_v = ~old_v;
    awaddr = 32'hC; wdata = new_v; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(posedge ACLK); #1;
    awvalid = 0; wvalid = 0;
    araddr = 32'hC; arvalid = 1; rready = 0;
    @(posedge ACLK); #1;
    arvalid = 0;
    void'(model_write(32'hC, new_v, 4'hF));
    n_checks++; if (rvalid !== 1'b1) $display("FAIL same_edge_rvalid got=%b exp=1", rvalid); else n_pass++;
    n_checks++; if (rdata !== old_v) $display("FAIL same_edge_old_data got=%h exp=%h", rdata, old_v); else n_pass++;
    n_checks++; if (reg_q[96 +: 32] !== new_v) $display("FAIL same_edge_reg3 got=%h exp=%h", reg_q[96 +: 32], new_v); else n_pass++;
    n_checks++; if (bvalid !== 1'b1) $display("FAIL same_edge_bvalid got=%b exp=1", bvalid); else n_pass++;
    rready = 1; bready = 1;
    @(posedge ACLK); #1;
    rready = 0; bready = 0;
    n_checks++; if (rvalid !== 1'b0 || bvalid !== 1'b0)
      $display("FAIL same_edge_release got=r%b b%b exp=0 0", rvalid, bvalid); else n_pass++;
    axi_read(32'hC, 0, d, resp, lat, tmo);
    n_checks++; if (tmo || d !== new_v) $display("FAIL same_edge_new_data got=%h exp=%h", d, new_v); else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp, eresp; logic [31:0] d, v; logic [NREGS-1:0] pm;
    int blat, bheld, pc, po, rib, lat; bit tmo;
    v = $urandom;
    axi_write(32'h40, v, 4'hF, 1, 0, 0, resp, blat, bheld, pm, pc, po, rib, tmo);
    eresp = model_write(32'h40, v, 4'hF);
    n_checks++; if (tmo || resp !== eresp) $display("FAIL oor_bresp got=%b exp=%b", resp, eresp); else n_pass++;
    n_checks++; if (pm !== exp_pulse(32'h40)) $display("FAIL oor_wr_pulse got=%b exp=%b", pm, exp_pulse(32'h40)); else n_pass++;
    n_checks++; if (reg_q !== model_flat()) $display("FAIL oor_regs got=%h exp=%h", reg_q, model_flat()); else n_pass++;
    axi_read(32'h40, 1, d, resp, lat, tmo);
    eresp = is_oor(32'h40) ? 2'b10 : 2'b00;
    n_checks++; if (tmo || resp !== eresp) $display("FAIL oor_rresp got=%b exp=%b", resp, eresp); else n_pass++;
    n_checks++; if (d !== (is_oor(32'h40) ? 32'h0 : model[idx_of(32'h40)]))
      $display("FAIL oor_rdata got=%h exp=%h", d, is_oor(32'h40) ? 32'h0 : model[idx_of(32'h40)]); else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] resp, eresp; logic [31:0] a, d, edata; logic [3:0] s; logic [NREGS-1:0] pm;
    int blat, bheld, pc, po, rib, lat; bit tmo;
    for (int it = 0; it < 40; it++) begin
      a = 32'($urandom_range(0, 95));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom; s = 4'($urandom);
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  resp, blat, bheld, pm, pc, po, rib, tmo);
        eresp = model_write(a, d, s);
        n_checks++; if (tmo || resp !== eresp || blat != 2)
          $display("FAIL rand_wr[%0d] addr=%h got=%b lat%0d exp=%b lat2", it, a, resp, blat, eresp); else n_pass++;
        n_checks++; if (pm !== exp_pulse(a) || pc != (is_oor(a) ? 0 : 1))
          $display("FAIL rand_pulse[%0d] got=%b/%0d exp=%b", it, pm, pc, exp_pulse(a)); else n_pass++;
        n_checks++; if (reg_q !== model_flat())
          $display("FAIL rand_regs[%0d] got=%h exp=%h", it, reg_q, model_flat()); else n_pass++;
      end else begin
        axi_read(a, $urandom_range(0, 3), d, resp, lat, tmo);
        edata = is_oor(a) ? 32'h0 : model[idx_of(a)];
        eresp = is_oor(a) ? 2'b10 : 2'b00;
        n_checks++; if (tmo || d !== edata || resp !== eresp || lat != 1)
          $display("FAIL rand_rd[%0d] addr=%h got=%h/%b exp=%h/%b", it, a, d, resp, edata, eresp); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int bseen = 0, pseen = 0;
    awaddr = 32'h4; awvalid = 1; wvalid = 0; bready = 0;
    araddr = 32'h4; arvalid = 1; rready = 0;
    @(posedge ACLK); #1;
    awvalid = 0; arvalid = 0;
    n_checks++; if (rvalid !== 1'b1 || awready !== 1'b0)
      $display("FAIL rstmid_pre got=rvalid %b awready %b exp=1 0", rvalid, awready); else n_pass++;
    ARESETn = 0;
    #2;
    for (int k = 0; k < NREGS; k++) model[k] = 32'h0;
    n_checks++; if (rvalid !== 1'b0) $display("FAIL rstmid_rvalid got=%b exp=0", rvalid); else n_pass++;
    n_checks++; if (reg_q !== model_flat()) $display("FAIL rstmid_regs got=%h exp=%h", reg_q, model_flat()); else n_pass++;
    @(posedge ACLK); #1;
    ARESETn = 1;
    @(posedge ACLK); #1;
    n_checks++; if (awready !== 1'b1) $display("FAIL rstmid_awready got=%b exp=1", awready); else n_pass++;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1;
    for (int c = 0; c < 10; c++) begin
      if (wvalid && wready) begin @(posedge ACLK); #1; wvalid = 0; end
      else begin @(posedge ACLK); #1; end
      if (bvalid) bseen++;
      if (wr_pulse != '0) pseen++;
    end
    wvalid = 0;
    n_checks++; if (bseen != 0 || pseen != 0) $display("FAIL rstmid_no_commit got=b%0d p%0d exp=0 0", bseen, pseen); else n_pass++;
    n_checks++; if (reg_q !== model_flat()) $display("FAIL rstmid_regs_after got=%h exp=%h", reg_q, model_flat()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_write_read();
    test_strobe_w_first();
    test_read_during_commit();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axil_reg_responder.md
# axil_reg_responder

AXI4-Lite responder (slave) exposing a bank of 32-bit read/write registers to a fabric master, such as the bus-driving stimulus used for the UART peripheral. It accepts write address and write data independently, applies byte strobes, returns one write response per write and one read beat per read address. Register contents and per-register write pulses are exported so peripheral logic (baud divisor, control, scratch) can be mapped behind a standard AXI-Lite port.

## Interface
- P_NUM_REGS, 8, number of 32-bit registers (power of two, 2..256)
- P_ADDR_WIDTH, 32, width of AWADDR/ARADDR; byte address, word index = ADDR[2 +: log2(P_NUM_REGS)]
- P_RESET_VAL, 32'h0000_0000, reset value loaded into every register

- ACLK  in  1  clock
- ARESETn  in  1  asynchronous, active-low reset
- S_AXI_AWADDR  in  P_ADDR_WIDTH  write byte address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables, bit i -> WDATA[8i+7:8i]
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake
- S_AXI_ARADDR  in  P_ADDR_WIDTH  read byte address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake
- reg_q  out  32*P_NUM_REGS  flat register contents, reg k at [32k+31:32k]
- wr_pulse  out  P_NUM_REGS  one-cycle strobe, bit k high after register k committed

## Operation
- Write path holds two capture flags, aw_held and w_held, plus captured address, data, strobe.
- AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID. AW and W may arrive in either order or same cycle.
- Commit: on the edge where aw_held && w_held (after capture), update bytes selected by WSTRB of register index, clear both flags, set BVALID, set BRESP. WSTRB=0 -> no byte changes, still OKAY response.
- BVALID held until BREADY sampled high; no new AW/W accepted while BVALID=1 (one outstanding write).
- Read path: ARREADY = !RVALID. On AR handshake, RDATA/RRESP registered from current register bank, RVALID set next edge; held stable until RREADY.
- Address bits [1:0] ignored. Address above P_NUM_REGS*4-1: see Configuration.
- Read and write paths fully independent; may be active in same cycle.

## Timing
- Reset (async assert, sync-to-ACLK release expected from system): BVALID=0, BRESP=00, RVALID=0, RDATA=0, RRESP=00, wr_pulse=0, all registers=P_RESET_VAL, flags cleared; AWREADY=WREADY=ARREADY=1 after reset.
- AW and W handshake same edge T -> commit edge T+1 -> BVALID=1 in cycle after T+1; wr_pulse[k]=1 that same cycle only.
- AW at T, W at T+n -> commit at T+n+1.
- BREADY already high when BVALID rises -> BVALID clears next edge; minimum write-to-write spacing 3 cycles.
- AR handshake at T -> RVALID=1 after T; RREADY high -> back-to-back reads every 2 cycles.
- Read of register k at same edge as write commit to k returns pre-write value.
- Reset mid-transaction: all captured state dropped, pending BVALID/RVALID cleared, no commit.

## Configuration
- AXIL_REG_SLVERR_EN defined: out-of-range address -> write discarded, BRESP=2'b10 (SLVERR); read returns RDATA=0, RRESP=2'b10. No wr_pulse.
- Not defined: upper address bits ignored, index wraps modulo P_NUM_REGS; all responses OKAY (00).

## Test plan
- Reset, then check AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0, reg_q all zero.
- AW addr 0x8 and W 0x0000_0006 strobe 1111 same cycle, BREADY high -> BVALID 2 cycles later, BRESP=00, reg 2=6, wr_pulse[2] single cycle; read 0x8 -> RDATA=6, RRESP=00.
- W 0xAABB_CCDD strobe 0101 three cycles before AW addr 0x4 onto reg value 0x1122_3344 -> reg 1=0x11BB_33DD; BVALID held while BREADY low for 5 cycles, AWREADY=0 during that.
- Write commit to reg 3 on same edge as AR to 0xC -> RDATA = old value; next read returns new value.
- Address 0x40 (P_NUM_REGS=8): with AXIL_REG_SLVERR_EN BRESP=10, RRESP=10, RDATA=0, no register change; without it access hits reg 0, responses 00.
- Assert ARESETn low while aw_held=1 and RVALID=1 -> RVALID=0, subsequent W alone never commits, registers at reset value.
